// File: rtl/tx_packet_framer.sv
// Transmit packet framer: preamble (0101...), sync word, then payload bytes MSB-first, one symbol per clk_enable.
// Optional build macro TX_CRC8_EN appends a CRC-8 (poly 0x07, init 0x00) trailer after the payload.
module tx_packet_framer #(
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int MAX_LEN_WIDTH    = 8,
    parameter int SYNC_WIDTH       = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = 16'h2DD4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_enable,
    input  logic [MAX_WINDOW_WIDTH-1:0] TX_PD_LENGTH,
    input  logic [MAX_LEN_WIDTH-1:0]    TX_PAYLOAD_LEN,
    input  logic                        start,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        BPSK,
    output logic                        tx_active,
    output logic                        tx_done,
    output logic                        tx_error
);

    localparam int SYNC_CNT_W = (SYNC_WIDTH > 1) ? $clog2(SYNC_WIDTH) : 1;
    localparam logic [SYNC_CNT_W-1:0] SYNC_LAST = SYNC_CNT_W'(SYNC_WIDTH - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] SYNC     = 3'd2;
    localparam logic [2:0] PAYLOAD  = 3'd3;
`ifdef TX_CRC8_EN
    localparam logic [2:0] CRC      = 3'd4;
`endif

    logic [2:0]                  state;
    logic                        pending;
    logic [MAX_WINDOW_WIDTH-1:0] lat_l;
    logic [MAX_WINDOW_WIDTH-1:0] pre_idx;
    logic [MAX_LEN_WIDTH-1:0]    lat_n;
    logic [MAX_LEN_WIDTH-1:0]    acc_cnt;
    logic [MAX_LEN_WIDTH-1:0]    sent_cnt;
    logic [SYNC_CNT_W-1:0]       sync_idx;
    logic [SYNC_WIDTH-1:0]       sync_shift;
    logic [2:0]                  bit_idx;
    logic [7:0]                  hold_reg;
    logic                        hold_valid;
    logic [7:0]                  shift_reg;
`ifdef TX_CRC8_EN
    logic [7:0]                  crc;
`endif

    logic pre_last;
    logic sync_last;
    logic byte_last;
    logic at_byte_boundary;
    logic more_bytes;
    logic need_byte;
    logic load_byte;
    logic underrun;
    logic payload_done;
    logic end_packet;
    logic xfer;

`ifdef TX_CRC8_EN
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    assign data_ready = ((state == SYNC) || (state == PAYLOAD)) && !hold_valid && (acc_cnt < lat_n);
    assign xfer       = data_ready && data_valid;

    // Byte boundaries happen at the end of the sync word and at the end of every payload byte.
    always_comb begin
        pre_last         = (pre_idx + MAX_WINDOW_WIDTH'(1)) == lat_l;
        sync_last        = (sync_idx == SYNC_LAST);
        byte_last        = (bit_idx == 3'd7);
        at_byte_boundary = ((state == SYNC) && sync_last) || ((state == PAYLOAD) && byte_last);
        more_bytes       = (sent_cnt != lat_n);
        need_byte        = clk_enable && at_byte_boundary && more_bytes;
        load_byte        = need_byte && hold_valid;
        underrun         = need_byte && !hold_valid;
        payload_done     = clk_enable && at_byte_boundary && !more_bytes;
`ifdef TX_CRC8_EN
        end_packet       = clk_enable && (state == CRC) && byte_last;
`else
        end_packet       = payload_done;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 1'b0;
            lat_l      <= '0;
            lat_n      <= '0;
            pre_idx    <= '0;
            acc_cnt    <= '0;
            sent_cnt   <= '0;
            sync_idx   <= '0;
            sync_shift <= '0;
            bit_idx    <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shift_reg  <= '0;
            BPSK       <= 1'b0;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
`ifdef TX_CRC8_EN
            crc        <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            if (start && (state == IDLE)) begin
                pending <= 1'b1;
            end

            if (xfer) begin
                hold_reg   <= data_in;
                hold_valid <= 1'b1;
                acc_cnt    <= acc_cnt + MAX_LEN_WIDTH'(1);
            end

            // Plain symbol advances; byte boundaries and packet end are handled below and take priority.
            if (clk_enable) begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            pending    <= 1'b0;
                            lat_l      <= TX_PD_LENGTH;
                            lat_n      <= TX_PAYLOAD_LEN;
                            acc_cnt    <= '0;
                            sent_cnt   <= '0;
                            pre_idx    <= '0;
                            sync_idx   <= '0;
                            bit_idx    <= '0;
                            hold_valid <= 1'b0;
                            tx_active  <= 1'b1;
`ifdef TX_CRC8_EN
                            crc        <= '0;
`endif
                            if (TX_PD_LENGTH != '0) begin
                                state <= PREAMBLE;
                                BPSK  <= 1'b0;
                            end else begin
                                state      <= SYNC;
                                BPSK       <= SYNC_WORD[SYNC_WIDTH-1];
                                sync_shift <= SYNC_WORD << 1;
                            end
                        end
                    end
                    PREAMBLE: begin
                        if (pre_last) begin
                            state      <= SYNC;
                            sync_idx   <= '0;
                            BPSK       <= SYNC_WORD[SYNC_WIDTH-1];
                            sync_shift <= SYNC_WORD << 1;
                        end else begin
                            pre_idx <= pre_idx + MAX_WINDOW_WIDTH'(1);
                            BPSK    <= ~BPSK;
                        end
                    end
                    SYNC: begin
                        if (!sync_last) begin
                            sync_idx   <= sync_idx + SYNC_CNT_W'(1);
                            BPSK       <= sync_shift[SYNC_WIDTH-1];
                            sync_shift <= sync_shift << 1;
                        end
                    end
                    PAYLOAD: begin
                        if (!byte_last) begin
                            bit_idx   <= bit_idx + 3'd1;
                            BPSK      <= shift_reg[7];
                            shift_reg <= {shift_reg[6:0], 1'b0};
                        end
                    end
`ifdef TX_CRC8_EN
                    CRC: begin
                        if (!byte_last) begin
                            bit_idx   <= bit_idx + 3'd1;
                            BPSK      <= shift_reg[7];
                            shift_reg <= {shift_reg[6:0], 1'b0};
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end

            if (load_byte) begin
                state      <= PAYLOAD;
                BPSK       <= hold_reg[7];
                shift_reg  <= {hold_reg[6:0], 1'b0};
                bit_idx    <= '0;
                hold_valid <= 1'b0;
                sent_cnt   <= sent_cnt + MAX_LEN_WIDTH'(1);
`ifdef TX_CRC8_EN
                crc        <= crc8_byte(crc, hold_reg);
`endif
            end

`ifdef TX_CRC8_EN
            if (payload_done) begin
                state     <= CRC;
                BPSK      <= crc[7];
                shift_reg <= {crc[6:0], 1'b0};
                bit_idx   <= '0;
            end
`endif

            // Normal end and underrun abort both return to IDLE and drop any half-fetched byte.
            if (end_packet || underrun) begin
                state      <= IDLE;
                BPSK       <= 1'b0;
                tx_active  <= 1'b0;
                hold_valid <= 1'b0;
                tx_done    <= end_packet;
                tx_error   <= underrun;
            end
        end
    end

endmodule

// File: tb/tb_tx_packet_framer.sv
// Scoreboard bench for tx_packet_framer: a reference model queues expected symbols/end events per packet,
// and a monitor pops and compares them at every clk_enable edge. Honours TX_CRC8_EN when defined.
module tb_tx_packet_framer;

    typedef struct packed {
        logic is_end;
        logic val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clk_enable;
    logic [7:0] TX_PD_LENGTH;
    logic [7:0] TX_PAYLOAD_LEN;
    logic       start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       BPSK;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    int checks = 0;
    int errors = 0;
    int ce_period = 4;
    int ce_cnt = 0;
    int active_clks = 0;
    int ready_seen = 0;
    int ends_seen = 0;
    logic mon_enable = 1'b0;
    logic ce_q = 1'b0;
    logic will_xfer = 1'b0;
    logic src_gap = 1'b0;
    exp_t mon_e;
    exp_t exp_q[$];
    logic [7:0] src_q[$];
    logic [7:0] pkt_bytes[$];

    tx_packet_framer dut (
        .clk            (clk),
        .rst            (rst),
        .clk_enable     (clk_enable),
        .TX_PD_LENGTH   (TX_PD_LENGTH),
        .TX_PAYLOAD_LEN (TX_PAYLOAD_LEN),
        .start          (start),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .BPSK           (BPSK),
        .tx_active      (tx_active),
        .tx_done        (tx_done),
        .tx_error       (tx_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Symbol strobe: one clk high every ce_period clocks, changed shortly after the rising edge.
    initial begin
        clk_enable = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ce_cnt >= ce_period - 1) begin
                clk_enable = 1'b1;
                ce_cnt = 0;
            end else begin
                clk_enable = 1'b0;
                ce_cnt++;
            end
        end
    end

    always @(posedge clk) ce_q <= clk_enable;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not expected by the scoreboard or bound expired", name);
    endtask

    // Byte source: answers data_ready within at most one idle clock, keeps data_in at the queue head.
    initial begin
        data_valid = 1'b0;
        data_in = 8'h00;
        forever begin
            @(negedge clk);
            will_xfer = data_valid && data_ready && !rst;
            @(posedge clk);
            #3;
            if (will_xfer && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() == 0) begin
                data_valid = 1'b0;
                src_gap = 1'b0;
            end else if (!data_valid && !src_gap && ($urandom_range(0, 1) == 1)) begin
                src_gap = 1'b1;
            end else begin
                src_gap = 1'b0;
                data_valid = 1'b1;
                data_in = src_q[0];
            end
        end
    end

    // Monitor: every clk_enable edge either shows a symbol or a completion pulse.
    always @(negedge clk) begin
        if (mon_enable && !rst) begin
            if (tx_active) active_clks++;
            if (data_ready) ready_seen++;
            if (ce_q) begin
                if (tx_active) begin
                    if (exp_q.size() == 0) reportFail("extra_symbol");
                    else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("symbol_slot_is_end", 32'(mon_e.is_end), 32'd0);
                        if (!mon_e.is_end) checkOutput("bpsk", 32'(BPSK), 32'(mon_e.val));
                    end
                end else if (tx_done || tx_error) begin
                    ends_seen++;
                    if (exp_q.size() == 0) reportFail("extra_end");
                    else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("end_slot_is_end", 32'(mon_e.is_end), 32'd1);
                        checkOutput("end_is_error", 32'(tx_error), 32'(mon_e.val));
                        checkOutput("end_is_done", 32'(tx_done), 32'(!mon_e.val));
                        checkOutput("end_bpsk", 32'(BPSK), 32'd0);
                    end
                end
            end else begin
                checkOutput("pulse_width", 32'(tx_done | tx_error), 32'd0);
            end
        end
    end

    // Reference model: symbol list from the framing rules; returns number of symbols before the end event.
    function automatic int build_expected(input int l, input int n, input int k);
        logic [15:0] sw;
        logic [7:0]  c;
        logic [7:0]  b;
        logic        fb;
        int          nsym;
        int          nb;
        sw = 16'h2DD4;
        c = 8'h00;
        nsym = 0;
        nb = (k < n) ? k : n;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back('{is_end: 1'b0, val: 1'((i % 2) == 1)});
            nsym++;
        end
        for (int i = 15; i >= 0; i--) begin
            exp_q.push_back('{is_end: 1'b0, val: sw[i]});
            nsym++;
        end
        for (int j = 0; j < nb; j++) begin
            b = pkt_bytes[j];
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back('{is_end: 1'b0, val: b[i]});
                nsym++;
                fb = c[7] ^ b[i];
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        if (k < n) begin
            exp_q.push_back('{is_end: 1'b1, val: 1'b1});
        end else begin
`ifdef TX_CRC8_EN
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back('{is_end: 1'b0, val: c[i]});
                nsym++;
            end
`endif
            exp_q.push_back('{is_end: 1'b1, val: 1'b0});
        end
        return nsym;
    endfunction

    task automatic startPulse();
        @(posedge clk);
        #3;
        while (clk_enable) begin
            @(posedge clk);
            #3;
        end
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #3;
        mon_enable = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        src_q.delete();
        exp_q.delete();
        data_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #3;
        checkOutput("reset_bpsk", 32'(BPSK), 32'd0);
        checkOutput("reset_tx_active", 32'(tx_active), 32'd0);
        checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
        checkOutput("reset_tx_error", 32'(tx_error), 32'd0);
        checkOutput("reset_data_ready", 32'(data_ready), 32'd0);
        rst = 1'b0;
        mon_enable = 1'b1;
    endtask

    task automatic waitEnd(input int budget, input string name);
        int e0;
        int t;
        e0 = ends_seen;
        for (t = 0; t < budget; t++) begin
            @(posedge clk);
            if (ends_seen != e0) break;
        end
        if (ends_seen == e0) begin
            reportFail(name);
            doReset(2);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic setupPacket(input int l, input int n, input int k, input int period, output int nsym);
        ce_period = period;
        repeat (2 * period + 2) @(posedge clk);
        #3;
        exp_q.delete();
        nsym = build_expected(l, n, k);
        src_q.delete();
        for (int j = 0; j < k; j++) src_q.push_back(pkt_bytes[j]);
        TX_PD_LENGTH = 8'(l);
        TX_PAYLOAD_LEN = 8'(n);
        active_clks = 0;
        ready_seen = 0;
    endtask

    task automatic applyStimulus(input int l, input int n, input int k, input int period);
        int nsym;
        setupPacket(l, n, k, period, nsym);
        startPulse();
        waitEnd((nsym + 8) * period + 60, "packet_end_timeout");
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("source_drained", 32'(src_q.size()), 32'd0);
        checkOutput("active_clks", 32'(active_clks), 32'(nsym * period));
    endtask

    task automatic fillBytes(input int n);
        pkt_bytes.delete();
        for (int j = 0; j < n; j++) pkt_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int nsym;
        int t;
        int l;
        int n;
        int k;
        rst = 1'b1;
        start = 1'b0;
        TX_PD_LENGTH = 8'd0;
        TX_PAYLOAD_LEN = 8'd0;
        doReset(3);

        $display("[TB] L=8 N=2 bytes A5 3C, strobe every 4 clk");
        pkt_bytes = '{8'hA5, 8'h3C};
        applyStimulus(8, 2, 2, 4);

        $display("[TB] L=0 N=0, sync word only");
        pkt_bytes.delete();
        applyStimulus(0, 0, 0, 3);
        checkOutput("n0_data_ready_seen", 32'(ready_seen), 32'd0);

        $display("[TB] L=4 N=1 with no data: underrun");
        fillBytes(1);
        applyStimulus(4, 1, 0, 4);

        $display("[TB] reset during second payload byte");
        fillBytes(3);
        setupPacket(8, 3, 3, 4, nsym);
        startPulse();
        for (t = 0; t < 400 && exp_q.size() > 14; t++) @(posedge clk);
        if (exp_q.size() > 14) reportFail("mid_reset_wait");
        doReset(1);
        pkt_bytes = '{8'hA5, 8'h3C};
        applyStimulus(8, 2, 2, 4);

        $display("[TB] start during an active packet is ignored");
        fillBytes(1);
        setupPacket(6, 1, 1, 3, nsym);
        startPulse();
        for (t = 0; t < 100 && !tx_active; t++) @(posedge clk);
        checkOutput("packet_started", 32'(tx_active), 32'd1);
        repeat (10) @(posedge clk);
        startPulse();
        waitEnd((nsym + 8) * 3 + 60, "ignored_start_end_timeout");
        active_clks = 0;
        repeat (60) @(posedge clk);
        checkOutput("ignored_start_idle_active", 32'(active_clks), 32'd0);
        checkOutput("ignored_start_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] N=1 byte 01, CRC trailer only when TX_CRC8_EN");
        pkt_bytes = '{8'h01};
        applyStimulus(2, 1, 1, 3);

        $display("[TB] randomized packets");
        for (int i = 0; i < 12; i++) begin
            l = $urandom_range(0, 11);
            n = $urandom_range(0, 4);
            k = n;
            if (n > 0 && $urandom_range(0, 3) == 0) k = $urandom_range(0, n - 1);
            fillBytes(n);
            applyStimulus(l, n, k, $urandom_range(2, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
